// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for sync_fifo_param and its verification environment.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int AF_DEFAULT     = DEF_DEPTH - 2;
    localparam int AE_DEFAULT     = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake, thresholds and status of sync_fifo_param.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    localparam int AW = clog2(DEPTH);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  flush;
    logic [AW:0]           af_thresh;
    logic [AW:0]           ae_thresh;
    logic                  err_clr;
    logic [AW:0]           fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_almost_full;
    logic                  fifo_almost_empty;
    logic                  fifo_overflow;
    logic                  fifo_underflow;

    modport master (
        output wr_en, data_in, rd_en, flush, af_thresh, ae_thresh, err_clr,
        input  data_out, rd_valid, fifo_count, fifo_full, fifo_empty,
               fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
    );
    modport slave (
        input  wr_en, data_in, rd_en, flush, af_thresh, ae_thresh, err_clr,
        output data_out, rd_valid, fifo_count, fifo_full, fifo_empty,
               fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port register array, one write port and one synchronous read port, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**AW];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // A read of the slot being written in the same cycle returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, registered read strobe, sticky error flags and flush.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input logic             clk,
    input logic             rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]           w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, count_q, count_d;
    logic                  rd_valid_q, rd_valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic                  out_zero_q, out_zero_d;
    logic                  full, empty, rd_acc, wr_acc, wr_do, rd_do;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    always_comb begin
        full       = (w_ptr_q[AW] != r_ptr_q[AW]) && (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);
        empty      = w_ptr_q == r_ptr_q;
        rd_acc     = bus.rd_en && !empty;
        wr_acc     = bus.wr_en && (!full || rd_acc);
        wr_do      = wr_acc && !bus.flush;
        rd_do      = rd_acc && !bus.flush;
        w_ptr_d    = bus.flush ? '0 : w_ptr_q + (AW+1)'(wr_do);
        r_ptr_d    = bus.flush ? '0 : r_ptr_q + (AW+1)'(rd_do);
        count_d    = bus.flush ? '0 : count_q + (AW+1)'(wr_do) - (AW+1)'(rd_do);
        rd_valid_d = rd_do;
        out_zero_d = out_zero_q && !rd_do;
        ovf_d      = (ovf_q && !bus.err_clr) || (bus.wr_en && !wr_acc && !bus.flush);
        unf_d      = (unf_q && !bus.err_clr) || (bus.rd_en && !rd_acc && !bus.flush);
    end

    // The array has no reset, so data_out is forced to zero until the first read after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            out_zero_q <= 1'b1;
        end else begin
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            out_zero_q <= out_zero_d;
        end
    end

    fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_mem (
        .clk     (clk),
        .wr_en   (wr_do),
        .wr_addr (w_ptr_q[AW-1:0]),
        .wr_data (bus.data_in),
        .rd_en   (rd_do),
        .rd_addr (r_ptr_q[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    assign bus.data_out          = out_zero_q ? '0 : mem_rd_data;
    assign bus.rd_valid          = rd_valid_q;
    assign bus.fifo_count        = count_q;
    assign bus.fifo_full         = full;
    assign bus.fifo_empty        = empty;
    assign bus.fifo_almost_full  = count_q >= bus.af_thresh;
    assign bus.fifo_almost_empty = count_q <= bus.ae_thresh;
    assign bus.fifo_overflow     = ovf_q;
    assign bus.fifo_underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed stimulus with a scoreboard queue of expected read data,
// drained by a monitor whenever rd_valid is seen.
module tb_sync_fifo_param;
    import fifo_pkg::*;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int D  = DEF_DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q [$];

    sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();
    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        bus.wr_en = w;
        bus.data_in = d;
        bus.rd_en = r;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (bus.fifo_full !== (bus.fifo_count == 5'(D)) || bus.fifo_empty !== (bus.fifo_count == 5'd0)) begin
                fails++;
                $display("FAIL flag_consistency: count=%0d full=%b empty=%b", bus.fifo_count, bus.fifo_full, bus.fifo_empty);
            end
            if (bus.rd_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_read: got 0x%0h with nothing expected", bus.data_out);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (bus.data_out !== e) begin
                        fails++;
                        $display("FAIL read_data: got 0x%0h expected 0x%0h", bus.data_out, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.data_in = '0;
        bus.flush = 1'b0;
        bus.err_clr = 1'b0;
        bus.af_thresh = 5'd14;
        bus.ae_thresh = 5'd2;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_count", bus.fifo_count, 0);
        check("reset_empty", bus.fifo_empty, 1);
        check("reset_full", bus.fifo_full, 0);
        check("reset_rd_valid", bus.rd_valid, 0);
        check("reset_data_out", bus.data_out, 0);
        check("reset_overflow", bus.fifo_overflow, 0);
        check("reset_underflow", bus.fifo_underflow, 0);
        check("reset_almost_empty", bus.fifo_almost_empty, 1);

        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            check("fill_count", bus.fifo_count, i);
            check("fill_almost_full", bus.fifo_almost_full, i >= 14);
            check("fill_almost_empty", bus.fifo_almost_empty, i <= 2);
            check("fill_full", bus.fifo_full, i == 16);
        end

        cyc(1'b1, 8'hAA, 1'b0);
        check("ovf_count", bus.fifo_count, 16);
        check("ovf_set", bus.fifo_overflow, 1);
        cyc(1'b0, 8'h00, 1'b0);
        check("ovf_sticky", bus.fifo_overflow, 1);
        bus.af_thresh = 5'd17;
        #1 check("af_thresh_above_depth", bus.fifo_almost_full, 0);
        bus.af_thresh = 5'd16;
        #1 check("af_thresh_at_depth", bus.fifo_almost_full, 1);
        bus.af_thresh = 5'd14;
        bus.err_clr = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        check("ovf_cleared", bus.fifo_overflow, 0);

        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(8'(i));
            cyc(1'b0, 8'h00, 1'b1);
            check("drain_rd_valid", bus.rd_valid, 1);
        end
        check("drain_empty", bus.fifo_empty, 1);
        bus.af_thresh = 5'd0;
        #1 check("af_thresh_zero", bus.fifo_almost_full, 1);
        bus.af_thresh = 5'd14;

        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h21 + i), 1'b0);
        check("refill_full", bus.fifo_full, 1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h21 + i));
            cyc(1'b1, 8'(8'h40 + i), 1'b1);
            check("stream_count", bus.fifo_count, 16);
            check("stream_no_ovf", bus.fifo_overflow, 0);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h29 + i));
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h40 + i));
        repeat (16) cyc(1'b0, 8'h00, 1'b1);
        check("stream_drained", bus.fifo_empty, 1);

        cyc(1'b1, 8'h55, 1'b1);
        check("empty_rw_underflow", bus.fifo_underflow, 1);
        check("empty_rw_count", bus.fifo_count, 1);
        check("empty_rw_rd_valid", bus.rd_valid, 0);
        exp_q.push_back(8'h55);
        cyc(1'b0, 8'h00, 1'b1);
        check("after_55_count", bus.fifo_count, 0);

        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h61 + i), 1'b0);
        check("pre_flush_count", bus.fifo_count, 5);
        bus.flush = 1'b1;
        cyc(1'b1, 8'h77, 1'b0);
        check("flush_count", bus.fifo_count, 0);
        check("flush_empty", bus.fifo_empty, 1);
        check("flush_no_ovf", bus.fifo_overflow, 0);
        check("flush_keeps_unf", bus.fifo_underflow, 1);
        check("flush_holds_data", bus.data_out, 8'h55);

        bus.err_clr = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        check("set_beats_clear", bus.fifo_underflow, 1);
        bus.err_clr = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        check("unf_cleared", bus.fifo_underflow, 0);

        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h81 + i), 1'b0);
        exp_q.push_back(8'h81);
        cyc(1'b0, 8'h00, 1'b1);
        check("pre_reset_count", bus.fifo_count, 9);
        check("pre_reset_data", bus.data_out, 8'h81);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_count", bus.fifo_count, 0);
        check("async_empty", bus.fifo_empty, 1);
        check("async_rd_valid", bus.rd_valid, 0);
        check("async_data_out", bus.data_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_reset_empty", bus.fifo_empty, 1);
        cyc(1'b0, 8'h00, 1'b1);
        check("post_reset_no_data", bus.rd_valid, 0);
        check("post_reset_underflow", bus.fifo_underflow, 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
